// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter: lock FSM encoding
// and default sizing for the data path, path count and burst length.
package rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // no current owner
        ST_LOCK = 1'b1    // an owner holds the output for up to BURST beats
    } arb_state_t;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_NPATH  = 4;
    localparam int DEF_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: scans the request vector starting at a given
// index (wrapping around) and returns the first requester as one-hot and
// as an index, plus a flag saying whether any requester was found.
module rr_pick #(
    parameter int NPATH = 4,
    parameter int IW    = $clog2(NPATH)
) (
    input  logic [NPATH-1:0] req,
    input  logic [IW-1:0]    start,
    output logic [NPATH-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             found
);

    // First requester at or after start, in wrapping order.
    always_comb begin
        int pos_s;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos_s  = 0;
        for (int i = 0; i < NPATH; i++) begin
            pos_s = (int'(start) + i) % NPATH;
            if (!found && req[pos_s]) begin
                found         = 1'b1;
                onehot[pos_s] = 1'b1;
                idx           = pos_s[IW-1:0];
            end else begin
                // an earlier position already won, or this path is idle
                found = found;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with burst locking. An owner keeps the grant for up
// to BURST consecutive beats while it keeps requesting; after that (or when
// it drops its request) the next requester after the previous owner wins in
// the same cycle. Winning data is captured into a one-deep output register
// that obeys a valid/ready handshake with the downstream consumer.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int DWIDTH = DEF_DWIDTH,
    parameter  int NPATH  = DEF_NPATH,
    parameter  int BURST  = DEF_BURST,
    localparam int IW     = $clog2(NPATH),
    localparam int CW     = $clog2(BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPATH-1:0]        req_i,
    input  logic [NPATH*DWIDTH-1:0] data_i,
    output logic [NPATH-1:0]        gnt_o,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [DWIDTH-1:0]       data_o,
    output logic [IW-1:0]           src_o
);

    arb_state_t         state_r, nxt_state_s;
    logic [IW-1:0]      last_r, nxt_last_s;     // current/previous owner
    logic [CW-1:0]      cnt_r, nxt_cnt_s;       // beats granted in this burst
    logic               accept_s;
    logic [IW-1:0]      start_s;
    logic [NPATH-1:0]   pick_onehot_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_found_s;
    logic [NPATH-1:0]   grant_s;
    logic               grant_valid_s;
    logic [IW-1:0]      grant_idx_s;

    // Output register can take a beat when empty or being drained.
    always_comb begin
        accept_s = !valid_o || ready_i;
    end

    // Round-robin scan starts one past the previous owner.
    always_comb begin
        if (last_r == IW'(NPATH - 1)) begin
            start_s = '0;
        end else begin
            start_s = last_r + IW'(1);
        end
    end

    rr_pick #(
        .NPATH (NPATH),
        .IW    (IW)
    ) u_pick (
        .req    (req_i),
        .start  (start_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .found  (pick_found_s)
    );

    // Lock FSM next state and grant decision.
    always_comb begin
        nxt_state_s   = state_r;
        nxt_last_s    = last_r;
        nxt_cnt_s     = cnt_r;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        grant_idx_s   = last_r;
        if (!accept_s) begin
            // downstream stalled: everything holds, nothing granted
            nxt_state_s = state_r;
        end else if ((state_r == ST_LOCK) && req_i[last_r] && (cnt_r < CW'(BURST))) begin
            grant_s[last_r] = 1'b1;
            grant_valid_s   = 1'b1;
            nxt_cnt_s       = cnt_r + CW'(1);
        end else if (pick_found_s) begin
            // burst exhausted, owner released, or idle: re-arbitrate now
            grant_s       = pick_onehot_s;
            grant_valid_s = 1'b1;
            grant_idx_s   = pick_idx_s;
            nxt_last_s    = pick_idx_s;
            nxt_cnt_s     = CW'(1);
            nxt_state_s   = ST_LOCK;
        end else begin
            nxt_state_s = ST_IDLE;
            nxt_cnt_s   = '0;
        end
    end

    // Grant is suppressed while reset is asserted.
    always_comb begin
        if (rst) begin
            gnt_o = '0;
        end else begin
            gnt_o = grant_s;
        end
    end

    // Lock FSM state, owner and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= IW'(NPATH - 1);
            cnt_r   <= '0;
        end else begin
            state_r <= nxt_state_s;
            last_r  <= nxt_last_s;
            cnt_r   <= nxt_cnt_s;
        end
    end

    // Output register: load the winner, drain when accepted, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            src_o   <= '0;
        end else if (accept_s && grant_valid_s) begin
            valid_o <= 1'b1;
            data_o  <= data_i[int'(grant_idx_s)*DWIDTH +: DWIDTH];
            src_o   <= grant_idx_s;
        end else if (accept_s) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_o;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with default parameters (DWIDTH=8, NPATH=4,
// BURST=4). Path k carries data 8'hA0+k. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 unit later, mid-cycle.
module tb_rr_arbiter;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req_i;
    logic [NP*DW-1:0] data_i;
    logic [NP-1:0]    gnt_o;
    logic             ready_i;
    logic             valid_o;
    logic [DW-1:0]    data_o;
    logic [IW-1:0]    src_o;

    int n_vec  = 0;
    int n_miss = 0;

    rr_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .src_o   (src_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req_i   = 4'b1111;
        ready_i = 1'b1;
        for (int k = 0; k < NP; k++) begin
            data_i[k*DW +: DW] = 8'hA0 + 8'(k);
        end

        // reset state
        #2;
        check_val("rst_gnt",   32'(gnt_o),   32'h0);
        check_val("rst_valid", 32'(valid_o), 32'h0);
        check_val("rst_data",  32'(data_o),  32'h0);
        check_val("rst_src",   32'(src_o),   32'h0);
        next_cycle();
        check_val("rst_gnt_held", 32'(gnt_o), 32'h0);
        rst = 1'b0;

        // all paths requesting: bursts of four, rotating 0,1,2
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #1;
            check_val("rr_gnt", 32'(gnt_o), 32'(1 << (i / 4)));
            if (i > 0) begin
                check_val("rr_valid", 32'(valid_o), 32'h1);
                check_val("rr_src",   32'(src_o),   32'((i - 1) / 4));
                check_val("rr_data",  32'(data_o),  32'(8'hA0 + ((i - 1) / 4)));
            end else begin
                check_val("rr_first_valid", 32'(valid_o), 32'h0);
            end
        end

        // sole requester on path 2: continuous grants, no bubble
        next_cycle();
        req_i = 4'b0100;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) next_cycle();
            #1;
            check_val("sole_gnt",   32'(gnt_o),   32'h4);
            check_val("sole_valid", 32'(valid_o), 32'h1);
            check_val("sole_src",   32'(src_o),   32'h2);
        end

        // fresh start for owner-drop scenario
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst   = 1'b0;
        req_i = 4'b0011;
        #1;
        check_val("drop_c0", 32'(gnt_o), 32'h1);
        next_cycle();
        #1;
        check_val("drop_c1", 32'(gnt_o), 32'h1);
        next_cycle();
        req_i = 4'b0010;
        #1;
        check_val("drop_release", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i = 4'b0011;
        #1;
        check_val("drop_c3",     32'(gnt_o),  32'h2);
        check_val("drop_c3_src", 32'(src_o),  32'h1);
        check_val("drop_c3_dat", 32'(data_o), 32'hA1);
        // new owner started at cnt=1, so it keeps three more beats
        for (int c = 4; c < 6; c++) begin
            next_cycle();
            #1;
            check_val("drop_keep", 32'(gnt_o), 32'h2);
        end
        next_cycle();
        #1;
        check_val("drop_rotate", 32'(gnt_o), 32'h1);

        // backpressure: owner 0 holds with cnt=1
        for (int s = 0; s < 3; s++) begin
            next_cycle();
            ready_i = 1'b0;
            #1;
            check_val("stall_gnt",   32'(gnt_o),   32'h0);
            check_val("stall_valid", 32'(valid_o), 32'h1);
            check_val("stall_data",  32'(data_o),  32'hA0);
            check_val("stall_src",   32'(src_o),   32'h0);
        end
        for (int r = 0; r < 3; r++) begin
            next_cycle();
            ready_i = 1'b1;
            #1;
            check_val("resume_gnt", 32'(gnt_o), 32'h1);
        end
        next_cycle();
        #1;
        check_val("resume_rotate", 32'(gnt_o), 32'h2);

        // no requesters: valid drains, data/src hold
        next_cycle();
        req_i = 4'b0000;
        #1;
        check_val("idle_gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        #1;
        check_val("idle_valid", 32'(valid_o), 32'h0);
        check_val("idle_src",   32'(src_o),   32'h1);
        check_val("idle_data",  32'(data_o),  32'hA1);

        // reset mid-burst on path 2
        next_cycle();
        req_i = 4'b0100;
        #1;
        check_val("mrst_gnt0", 32'(gnt_o), 32'h4);
        next_cycle();
        #1;
        check_val("mrst_gnt1", 32'(gnt_o),  32'h4);
        check_val("mrst_src1", 32'(src_o),  32'h2);
        rst = 1'b1;
        #1;
        check_val("mrst_valid", 32'(valid_o), 32'h0);
        check_val("mrst_data",  32'(data_o),  32'h0);
        check_val("mrst_gnt",   32'(gnt_o),   32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check_val("mrst_regnt",  32'(gnt_o),   32'h4);
        check_val("mrst_nobeat", 32'(valid_o), 32'h0);
        next_cycle();
        req_i = 4'b0110;
        #1;
        check_val("mrst_c1",     32'(gnt_o),   32'h4);
        check_val("mrst_c1_vld", 32'(valid_o), 32'h1);
        check_val("mrst_c1_src", 32'(src_o),   32'h2);
        for (int b = 2; b < 4; b++) begin
            next_cycle();
            #1;
            check_val("mrst_keep", 32'(gnt_o), 32'h4);
        end
        next_cycle();
        #1;
        check_val("mrst_rotate", 32'(gnt_o), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
